hazard_stall_unit: RTL

- Companion to the forwarding logic in the LC-3b 5-stage pipeline.
- Handles every hazard that forwarding cannot resolve: load-use bubbles, store-data-after-load bubbles, global stalls while instruction or data memory is outstanding, and control flushes on a taken branch or jump resolved in MEM.
- Drives the PC and pipeline-register load enables, the bubble/flush controls, and saturating performance counters.

---
 rtl/hazard_stall_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller for the LC-3b 5-stage pipeline: load-use bubbles,
// memory-wait global stalls, taken-branch flushes and saturating perf counters.
//
// state    | meaning
// ---------+---------------------------------------------------------
// RUN      | pipeline advancing (or stall first seen this cycle)
// MEM_WAIT | a memory stall was seen on the previous edge, still waiting
module hazard_stall_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ex_is_load,
    input  logic             ex_regfile_write,
    input  logic [2:0]       ex_dest,
    input  logic [2:0]       id_sr1,
    input  logic [2:0]       id_sr2,
    input  logic [2:0]       id_dest,
    input  logic             id_uses_sr1,
    input  logic             id_uses_sr2,
    input  logic             id_is_store,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             mem_branch_taken,
    input  logic             perf_clr,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             id_ex_bubble,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] lu_bubbles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             imem_done_q, imem_done_d;
    logic             dmem_done_q, dmem_done_d;
    logic             out_of_reset_q, out_of_reset_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] lu_bubbles_q, lu_bubbles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic imem_pending;
    logic dmem_pending;
    logic global_stall;
    logic lu;
    logic take_flush;

    always_comb begin
        imem_pending = imem_req & ~imem_resp & ~imem_done_q;
        dmem_pending = dmem_req & ~dmem_resp & ~dmem_done_q;
        global_stall = imem_pending | dmem_pending;

        lu = ex_is_load & ex_regfile_write &
             ((id_uses_sr1 & (id_sr1 == ex_dest)) |
              (id_uses_sr2 & (id_sr2 == ex_dest)) |
              (id_is_store & (id_dest == ex_dest)));
        take_flush = mem_branch_taken & ~global_stall;
    end

    // Control outputs: everything held low until the first edge after reset.
    always_comb begin
        pc_load      = 1'b0;
        if_id_load   = 1'b0;
        id_ex_load   = 1'b0;
        ex_mem_load  = 1'b0;
        mem_wb_load  = 1'b0;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (out_of_reset_q && !global_stall) begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            if (take_flush) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end else if (lu) begin
                pc_load      = 1'b0;
                if_id_load   = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    // A response only needs remembering while the other side keeps us stalled.
    always_comb begin
        state_d        = state_q;
        out_of_reset_d = 1'b1;
        imem_done_d    = global_stall & (imem_done_q | imem_resp);
        dmem_done_d    = global_stall & (dmem_done_q | dmem_resp);
        case (state_q)
            RUN:      if (global_stall)  state_d = MEM_WAIT;
            MEM_WAIT: if (!global_stall) state_d = RUN;
            default:                     state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        lu_bubbles_d   = lu_bubbles_q;
        flush_count_d  = flush_count_q;
        if (perf_clr) begin
            stall_cycles_d = '0;
            lu_bubbles_d   = '0;
            flush_count_d  = '0;
        end else begin
            if (global_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
            if (id_ex_bubble && (lu_bubbles_q != '1))   lu_bubbles_d   = lu_bubbles_q + 1'b1;
            if (flush_if_id && (flush_count_q != '1))   flush_count_d  = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RUN;
            imem_done_q    <= 1'b0;
            dmem_done_q    <= 1'b0;
            out_of_reset_q <= 1'b0;
            stall_cycles_q <= '0;
            lu_bubbles_q   <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            imem_done_q    <= imem_done_d;
            dmem_done_q    <= dmem_done_d;
            out_of_reset_q <= out_of_reset_d;
            stall_cycles_q <= stall_cycles_d;
            lu_bubbles_q   <= lu_bubbles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign lu_bubbles   = lu_bubbles_q;
    assign flush_count  = flush_count_q;

endmodule
